axi_rd_arbiter: RTL
===================

Name: axi_rd_arbiter

Overview:
- Two-master to one-slave AXI read-channel arbiter with a single transaction outstanding at a time.
- Shares the core's single external AXI read port between the instruction-fetch master (IF, master 0) and the load/store master (MEM, master 1).
- Registers the winning AR request, issues it to the slave, then steers R beats back to the granted master until RLAST.
- Counts R beats against the captured ARLEN and flags length mismatches.

Parameters:
- ADDR_W, 32, AR address width.
- DATA_W, 64, R data width.
- ID_W, 4, ARID/RID width.
- LEN_W, 8, ARLEN width (beats = ARLEN+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- arvalid_m0 / arvalid_m1  in  1  AR valid from IF / MEM
- arready_m0 / arready_m1  out  1  AR ready to IF / MEM
- arid_m0 / arid_m1  in  ID_W  request ID
- araddr_m0 / araddr_m1  in  ADDR_W  request address
- arlen_m0 / arlen_m1  in  LEN_W  burst length
- arsize_m0 / arsize_m1  in  3  beat size
- arburst_m0 / arburst_m1  in  2  burst type
- rvalid_m0 / rvalid_m1  out  1  R valid to each master
- rready_m0 / rready_m1  in  1  R ready from each master
- rid_m, rdata_m, rresp_m, rlast_m  out  ID_W, DATA_W, 2, 1  R payload, shared by both masters; qualified by the per-master rvalid
- arvalid_s  out  1  AR valid to slave
- arready_s  in  1  AR ready from slave
- arid_s, araddr_s, arlen_s, arsize_s, arburst_s  out  ID_W, ADDR_W, LEN_W, 3, 2  registered AR payload
- rvalid_s, rid_s, rdata_s, rresp_s, rlast_s  in  1, ID_W, DATA_W, 2, 1  R channel from slave
- rready_s  out  1  R ready to slave
- busy  out  1  state != IDLE
- grant  out  1  master owning the current transaction (0 = IF, 1 = MEM)
- len_err  out  1  sticky beat-count mismatch flag

Behaviour:
- FSM states: IDLE, ADDR, DATA.
- Reset (async):
  - state = IDLE, grant = 0, last_grant = 1 (IF wins first tie).
  - All AR payload registers, the beat counter and len_err = 0.
  - All outputs 0.
- IDLE:
  - Winner is chosen combinationally from arvalid_m0/m1.
  - arready of the winner only is 1 in the same cycle; the handshake completes there.
  - On handshake, capture the winner's id/addr/len/size/burst, set grant, clear the beat counter, go to ADDR.
  - Single requester always wins. Both valid: priority per Optional Feature.
  - Loser's arready = 0; it holds its request.
- ADDR:
  - arvalid_s = 1 with captured payload; payload stable until arready_s.
  - Earliest arvalid_s is the cycle after the master handshake (1-cycle latency).
  - On arready_s, go to DATA. Both arready_m* = 0.
- DATA:
  - rvalid_m[grant] = rvalid_s; rvalid of the other master = 0.
  - rid_m/rdata_m/rresp_m/rlast_m pass through combinationally; driven 0 outside DATA.
  - rready_s = rready_m[grant]; the ungranted master's rready is ignored.
  - Each rvalid_s & rready_s beat increments the beat counter (LEN_W+1 bits).
  - A beat with rlast_s: return to IDLE, last_grant = grant.
  - If that beat's count != captured len, set len_err.
  - If the count exceeds len without rlast_s: set len_err and keep passing beats until rlast_s.
- len_err is cleared only by reset.
- Back-to-back transactions: a new grant occurs at earliest the cycle after the RLAST beat. Requests present during DATA wait.
- rvalid_s in IDLE/ADDR: ignored, rready_s = 0.
- Reset asserted mid-burst: immediate return to IDLE. The outstanding transaction is abandoned; no recovery is attempted.

Optional Feature:
- Macro AXI_ARB_RR_EN.
- Defined: round-robin. On a tie, the master not equal to last_grant wins.
- Undefined: fixed priority. MEM (m1) always wins ties; last_grant is still updated but unused.

Test Plan:
- Single IF read: arvalid_m0 with addr 0x8000_0000, len 0 → arready_m0 in the same cycle; arvalid_s next cycle with addr 0x8000_0000. One beat rdata 0x1122334455667788, rlast → rvalid_m0 = 1, rvalid_m1 = 0, back to IDLE, len_err = 0.
- Simultaneous requests, three back-to-back rounds, both always valid:
  - With AXI_ARB_RR_EN: grants m0, m1, m0.
  - Without: grants m1, m1, m1.
- Burst: m1 len 3, slave inserts rvalid_s gaps and m1 drops rready_m1 for 2 cycles → exactly 4 beats delivered in order; rready_s tracks rready_m1; busy falls the cycle after beat 4.
- Length error: m0 len 1, slave asserts rlast_s on beat 1 → len_err = 1 and stays 1 through later correct transactions.
- Slave stall: arready_s held low 5 cycles → arvalid_s and payload held stable for all 5; arriving m1 request sees arready_m1 = 0 throughout.
- Reset mid-burst: rst_n low during beat 2 of a len 3 burst → all outputs 0 immediately; after release, an m1 request is granted normally.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Two-master (IF = m0, MEM = m1) to one-slave AXI read arbiter, one transaction in flight.
// Tie policy: fixed priority to MEM by default; round-robin when AXI_ARB_RR_EN is defined.
module axi_rd_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int ID_W   = 4,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              arvalid_m0,
   input  logic              arvalid_m1,
   output logic              arready_m0,
   output logic              arready_m1,
   input  logic [ID_W-1:0]   arid_m0,
   input  logic [ID_W-1:0]   arid_m1,
   input  logic [ADDR_W-1:0] araddr_m0,
   input  logic [ADDR_W-1:0] araddr_m1,
   input  logic [LEN_W-1:0]  arlen_m0,
   input  logic [LEN_W-1:0]  arlen_m1,
   input  logic [2:0]        arsize_m0,
   input  logic [2:0]        arsize_m1,
   input  logic [1:0]        arburst_m0,
   input  logic [1:0]        arburst_m1,
   output logic              rvalid_m0,
   output logic              rvalid_m1,
   input  logic              rready_m0,
   input  logic              rready_m1,
   output logic [ID_W-1:0]   rid_m,
   output logic [DATA_W-1:0] rdata_m,
   output logic [1:0]        rresp_m,
   output logic              rlast_m,
   output logic              arvalid_s,
   input  logic              arready_s,
   output logic [ID_W-1:0]   arid_s,
   output logic [ADDR_W-1:0] araddr_s,
   output logic [LEN_W-1:0]  arlen_s,
   output logic [2:0]        arsize_s,
   output logic [1:0]        arburst_s,
   input  logic              rvalid_s,
   input  logic [ID_W-1:0]   rid_s,
   input  logic [DATA_W-1:0] rdata_s,
   input  logic [1:0]        rresp_s,
   input  logic              rlast_s,
   output logic              rready_s,
   output logic              busy,
   output logic              grant,
   output logic              len_err,
   output logic [1:0]        state_dbg
);

   // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
   // a master holds valid and payload stable until that edge.
   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_e;

   state_e             state_q, state_d;
   logic               grant_q, grant_d;
   logic               last_grant_q, last_grant_d;
   logic [ID_W-1:0]    arid_q, arid_d;
   logic [ADDR_W-1:0]  araddr_q, araddr_d;
   logic [LEN_W-1:0]   arlen_q, arlen_d;
   logic [2:0]         arsize_q, arsize_d;
   logic [1:0]         arburst_q, arburst_d;
   logic [LEN_W:0]     beat_cnt_q, beat_cnt_d;
   logic               len_err_q, len_err_d;

   logic               tie_pick;
   logic               win;
   logic               rready_sel;
   logic               beat;
   logic [LEN_W:0]     len_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         arid_q       <= '0;
         araddr_q     <= '0;
         arlen_q      <= '0;
         arsize_q     <= '0;
         arburst_q    <= '0;
         beat_cnt_q   <= '0;
         len_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         arid_q       <= arid_d;
         araddr_q     <= araddr_d;
         arlen_q      <= arlen_d;
         arsize_q     <= arsize_d;
         arburst_q    <= arburst_d;
         beat_cnt_q   <= beat_cnt_d;
         len_err_q    <= len_err_d;
      end
   end

`ifdef AXI_ARB_RR_EN
   assign tie_pick = ~last_grant_q;
`else
   assign tie_pick = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      arid_d       = arid_q;
      araddr_d     = araddr_q;
      arlen_d      = arlen_q;
      arsize_d     = arsize_q;
      arburst_d    = arburst_q;
      beat_cnt_d   = beat_cnt_q;
      len_err_d    = len_err_q;

      arready_m0   = 1'b0;
      arready_m1   = 1'b0;
      arvalid_s    = 1'b0;
      rvalid_m0    = 1'b0;
      rvalid_m1    = 1'b0;
      rready_s     = 1'b0;
      rid_m        = '0;
      rdata_m      = '0;
      rresp_m      = '0;
      rlast_m      = 1'b0;

      win          = (arvalid_m0 & arvalid_m1) ? tie_pick : arvalid_m1;
      rready_sel   = grant_q ? rready_m1 : rready_m0;
      beat         = 1'b0;
      len_ext      = {1'b0, arlen_q};

      unique case (state_q)
         IDLE: begin
            // rst_n gating keeps arready low while reset is held with requests pending
            arready_m0 = rst_n & arvalid_m0 & ~win;
            arready_m1 = rst_n & arvalid_m1 & win;
            if (arvalid_m0 | arvalid_m1) begin
               state_d    = ADDR;
               grant_d    = win;
               arid_d     = win ? arid_m1    : arid_m0;
               araddr_d   = win ? araddr_m1  : araddr_m0;
               arlen_d    = win ? arlen_m1   : arlen_m0;
               arsize_d   = win ? arsize_m1  : arsize_m0;
               arburst_d  = win ? arburst_m1 : arburst_m0;
               beat_cnt_d = '0;
            end
         end
         ADDR: begin
            arvalid_s = 1'b1;
            if (arready_s) state_d = DATA;
         end
         DATA: begin
            rvalid_m0 = rvalid_s & ~grant_q;
            rvalid_m1 = rvalid_s & grant_q;
            rready_s  = rready_sel;
            rid_m     = rid_s;
            rdata_m   = rdata_s;
            rresp_m   = rresp_s;
            rlast_m   = rlast_s;
            beat      = rvalid_s & rready_sel;
            if (beat) begin
               beat_cnt_d = beat_cnt_q + {{LEN_W{1'b0}}, 1'b1};
               // beat_cnt_q is the zero-based index of this beat; the last one must be index arlen
               if (rlast_s) begin
                  if (beat_cnt_q != len_ext) len_err_d = 1'b1;
                  state_d      = IDLE;
                  last_grant_d = grant_q;
               end else if (beat_cnt_q >= len_ext) begin
                  len_err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign arid_s    = arid_q;
   assign araddr_s  = araddr_q;
   assign arlen_s   = arlen_q;
   assign arsize_s  = arsize_q;
   assign arburst_s = arburst_q;
   assign busy      = (state_q != IDLE);
   assign grant     = grant_q;
   assign len_err   = len_err_q;
   assign state_dbg = state_q;

endmodule
